nec_ir_tx: RTL

//   NEC-protocol infrared transmitter: serialises an 8-bit address and 8-bit command into an NEC frame.

---
 rtl/nec_ir_tx.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/nec_ir_tx.sv
// NEC infrared transmitter: leader, 32 data bits {~cmd,cmd,~addr,addr} LSB first, stop mark, gap.
// Define NEC_REPEAT_EN to add the tx_repeat input and the NEC repeat-code sequence.
module nec_ir_tx #(
  parameter int UNIT_CYCLES  = 28125,
  parameter int CARRIER_HALF = 658,
  parameter int GAP_UNITS    = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tx_valid,
  input  logic [7:0] tx_addr,
  input  logic [7:0] tx_cmd,
`ifdef NEC_REPEAT_EN
  input  logic       tx_repeat,
`endif
  output logic       tx_ready,
  output logic       busy,
  output logic       ir_env,
  output logic       ir_out,
  output logic [2:0] fsm_state
);

  localparam int CYC_W    = (UNIT_CYCLES > 1) ? $clog2(UNIT_CYCLES) : 1;
  localparam int UNIT_MAX = (GAP_UNITS > 16) ? GAP_UNITS : 16;
  localparam int UNIT_W   = $clog2(UNIT_MAX);
  localparam int PH_W     = $clog2(2 * CARRIER_HALF);

  typedef enum logic [2:0] {
    IDLE, LDR_MARK, LDR_SPACE, BIT_MARK, BIT_SPACE, STOP_MARK, GAP
`ifdef NEC_REPEAT_EN
    , RPT_SPACE
`endif
  } state_t;

  state_t            state;
  logic [CYC_W-1:0]  cyc;
  logic [UNIT_W-1:0] units;
  logic [UNIT_W-1:0] last_unit;
  logic [PH_W-1:0]   ph;
  logic [4:0]        bit_cnt;
  logic [31:0]       sr;
`ifdef NEC_REPEAT_EN
  logic              rpt;
`endif
  logic              is_mark;
  logic              unit_end;
  logic              state_done;

  assign fsm_state  = state;
  assign is_mark    = (state == LDR_MARK) || (state == BIT_MARK) || (state == STOP_MARK);
  assign unit_end   = (cyc == CYC_W'(UNIT_CYCLES - 1));
  assign state_done = unit_end && (units == last_unit);

  always_comb begin
    last_unit = '0;
    case (state)
      LDR_MARK:  last_unit = UNIT_W'(15);
      LDR_SPACE: last_unit = UNIT_W'(7);
      BIT_SPACE: last_unit = sr[0] ? UNIT_W'(2) : UNIT_W'(0);
      GAP:       last_unit = UNIT_W'(GAP_UNITS - 1);
`ifdef NEC_REPEAT_EN
      RPT_SPACE: last_unit = UNIT_W'(3);
`endif
      default:   last_unit = '0;
    endcase
  end

  // Handshake: a request is taken on the edge where tx_valid and tx_ready are both high;
  // tx_ready is high only in IDLE and the frame fields are sampled on that edge alone.
  // Every output is registered from the current state, so the whole waveform trails
  // the state register by one clock (envelope rises the cycle after accept).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      cyc      <= '0;
      units    <= '0;
      ph       <= '0;
      bit_cnt  <= '0;
      sr       <= '0;
      tx_ready <= 1'b1;
      busy     <= 1'b0;
      ir_env   <= 1'b0;
      ir_out   <= 1'b0;
`ifdef NEC_REPEAT_EN
      rpt      <= 1'b0;
`endif
    end else begin
      ir_env   <= is_mark;
      ir_out   <= is_mark && (ph < PH_W'(CARRIER_HALF));
      tx_ready <= (state == IDLE);
      busy     <= (state != IDLE);
      if (state == IDLE) begin
        if (tx_valid && tx_ready) begin
          state    <= LDR_MARK;
          sr       <= {~tx_cmd, tx_cmd, ~tx_addr, tx_addr};
          bit_cnt  <= '0;
          tx_ready <= 1'b0;
          busy     <= 1'b1;
`ifdef NEC_REPEAT_EN
          rpt      <= tx_repeat;
`endif
        end
      end else if (state_done) begin
        // Carrier phase restarts with every state so each mark begins on a high half.
        cyc   <= '0;
        units <= '0;
        ph    <= '0;
        case (state)
          LDR_MARK: begin
`ifdef NEC_REPEAT_EN
            state <= rpt ? RPT_SPACE : LDR_SPACE;
`else
            state <= LDR_SPACE;
`endif
          end
          LDR_SPACE: state <= BIT_MARK;
          BIT_MARK:  state <= BIT_SPACE;
          BIT_SPACE: begin
            sr      <= sr >> 1;
            bit_cnt <= bit_cnt + 5'd1;
            state   <= (bit_cnt == 5'd31) ? STOP_MARK : BIT_MARK;
          end
`ifdef NEC_REPEAT_EN
          RPT_SPACE: state <= STOP_MARK;
`endif
          STOP_MARK: state <= GAP;
          default:   state <= IDLE;
        endcase
      end else begin
        if (unit_end) begin
          cyc   <= '0;
          units <= units + 1'b1;
        end else begin
          cyc <= cyc + 1'b1;
        end
        ph <= (ph == PH_W'(2 * CARRIER_HALF - 1)) ? '0 : ph + 1'b1;
      end
    end
  end

endmodule
